// File: rtl/decode_queue.sv
// decode_queue: RV32I single-instruction decoder feeding a DEPTH-entry FIFO.
// Fetch pushes raw words through a valid/ready handshake, each word is decoded
// combinationally on the way in, and issue pops fully decoded entries in order.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_line,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_instr_type,
    output logic [5:0]       out_branch_type,
    output logic [2:0]       out_load_type,
    output logic             out_load_unsigned,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [11:0] instr_type;
        logic [5:0]  branch_type;
        logic [2:0]  load_type;
        logic        load_unsigned;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_line[6:0];
    assign funct3 = in_line[14:12];
    assign funct7 = in_line[31:25];

    logic raw_reg, raw_imm, raw_jal, raw_jalr, raw_branch;
    logic raw_load, raw_store, raw_lui, raw_auipc;
    logic dec_illegal;
    logic is_reg, is_imm, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_lui, is_auipc;
    logic sub_sra, write_rd, use_rs2;
    entry_t dec;

    // Classify the opcode and flag any encoding that RV32I does not define.
    always_comb begin
        raw_reg     = 1'b0;
        raw_imm     = 1'b0;
        raw_jal     = 1'b0;
        raw_jalr    = 1'b0;
        raw_branch  = 1'b0;
        raw_load    = 1'b0;
        raw_store   = 1'b0;
        raw_lui     = 1'b0;
        raw_auipc   = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                raw_reg = 1'b1;
                if (funct7 == 7'h00)
                    dec_illegal = 1'b0;
                else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
                    dec_illegal = 1'b0;
                else
                    dec_illegal = 1'b1;
            end
            7'b0010011: begin
                raw_imm = 1'b1;
                if (funct3 == 3'd1)
                    dec_illegal = (funct7 != 7'h00);
                else if (funct3 == 3'd5)
                    dec_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            7'b1101111: raw_jal = 1'b1;
            7'b1100111: begin
                raw_jalr    = 1'b1;
                dec_illegal = (funct3 != 3'd0);
            end
            7'b1100011: begin
                raw_branch  = 1'b1;
                dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            7'b0000011: begin
                raw_load    = 1'b1;
                dec_illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
            end
            7'b0100011: begin
                raw_store   = 1'b1;
                dec_illegal = (funct3 > 3'd2);
            end
            7'b0110111: raw_lui = 1'b1;
            7'b0010111: raw_auipc = 1'b1;
            default:    dec_illegal = 1'b1;
        endcase
    end

    // Build the decoded entry; an illegal word keeps only its trap flag and fields.
    always_comb begin
        is_reg    = raw_reg    & ~dec_illegal;
        is_imm    = raw_imm    & ~dec_illegal;
        is_jal    = raw_jal    & ~dec_illegal;
        is_jalr   = raw_jalr   & ~dec_illegal;
        is_branch = raw_branch & ~dec_illegal;
        is_load   = raw_load   & ~dec_illegal;
        is_store  = raw_store  & ~dec_illegal;
        is_lui    = raw_lui    & ~dec_illegal;
        is_auipc  = raw_auipc  & ~dec_illegal;

        sub_sra  = (is_reg & (funct7 == 7'h20) & ((funct3 == 3'd0) | (funct3 == 3'd5)))
                 | (is_imm & (funct3 == 3'd5) & (funct7 == 7'h20));
        write_rd = ~(is_store | is_branch | dec_illegal) & (in_line[11:7] != 5'd0);
        use_rs2  = is_reg | is_branch | is_store;

        dec            = '0;
        dec.instr_type = {is_auipc, is_lui, use_rs2, write_rd, sub_sra, is_store,
                          is_load, is_branch, is_jalr, is_jal, is_imm, is_reg};
        dec.rs1        = in_line[19:15];
        dec.rs2        = in_line[24:20];
        dec.rd         = in_line[11:7];
        dec.pc         = in_pc;
        dec.illegal    = dec_illegal;

        if (is_imm | is_jalr | is_load)
            dec.imm = {{20{in_line[31]}}, in_line[31:20]};
        else if (is_store)
            dec.imm = {{20{in_line[31]}}, in_line[31:25], in_line[11:7]};
        else if (is_branch)
            dec.imm = {{19{in_line[31]}}, in_line[31], in_line[7], in_line[30:25],
                       in_line[11:8], 1'b0};
        else if (is_jal)
            dec.imm = {{11{in_line[31]}}, in_line[31], in_line[19:12], in_line[20],
                       in_line[30:21], 1'b0};
        else if (is_lui | is_auipc)
            dec.imm = {in_line[31:12], 12'h000};

        if (is_branch) begin
            case (funct3)
                3'd0:    dec.branch_type = 6'b000001;
                3'd1:    dec.branch_type = 6'b000010;
                3'd4:    dec.branch_type = 6'b000100;
                3'd5:    dec.branch_type = 6'b001000;
                3'd6:    dec.branch_type = 6'b010000;
                3'd7:    dec.branch_type = 6'b100000;
                default: dec.branch_type = 6'b000000;
            endcase
        end

        if (is_load | is_store) begin
            case (funct3[1:0])
                2'd0:    dec.load_type = 3'b001;
                2'd1:    dec.load_type = 3'b010;
                2'd2:    dec.load_type = 3'b100;
                default: dec.load_type = 3'b000;
            endcase
        end
        dec.load_unsigned = is_load & funct3[2];
    end

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    entry_t             head;

    assign in_ready  = (count_q < CNT_W'(DEPTH)) & ~reset & ~flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state for pointers, occupancy and storage; flush empties the queue.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset because out_valid masks stale contents.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head              = mem_q[rd_ptr_q];
    assign out_instr_type    = head.instr_type;
    assign out_branch_type   = head.branch_type;
    assign out_load_type     = head.load_type;
    assign out_load_unsigned = head.load_unsigned;
    assign out_rs1           = head.rs1;
    assign out_rs2           = head.rs2;
    assign out_rd            = head.rd;
    assign out_imm           = head.imm;
    assign out_pc            = head.pc;
    assign out_illegal       = head.illegal;
    assign count             = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed testbench for decode_queue with DEPTH=4.
module tb_decode_queue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_line;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_instr_type;
    logic [5:0]  out_branch_type;
    logic [2:0]  out_load_type;
    logic        out_load_unsigned;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [2:0]  count;

    int checks;
    int errors;

    decode_queue #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr_type(out_instr_type), .out_branch_type(out_branch_type),
        .out_load_type(out_load_type), .out_load_unsigned(out_load_unsigned),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
        .count(count)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [31:0] line, input logic [31:0] pc);
        in_valid = 1'b1;
        in_line  = line;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready_high: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        push(32'h00500093, 32'h100);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %b expected 1", out_valid); end
        checks++; if (out_instr_type !== 12'h102) begin errors++; $display("[TB] FAIL addi_type: got %h expected 102", out_instr_type); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("[TB] FAIL addi_rd: got %0d expected 1", out_rd); end
        checks++; if (out_imm !== 32'd5) begin errors++; $display("[TB] FAIL addi_imm: got %h expected 5", out_imm); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("[TB] FAIL addi_pc: got %h expected 100", out_pc); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL addi_count_after_pop: got %0d expected 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_sub_beq();
        push(32'h402081B3, 32'h104);
        push(32'hFE208EE3, 32'h108);
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL subbeq_count: got %0d expected 2", count); end
        checks++; if (out_instr_type !== 12'h381) begin errors++; $display("[TB] FAIL sub_type: got %h expected 381", out_instr_type); end
        checks++; if ({out_rs1, out_rs2, out_rd} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("[TB] FAIL sub_regs: got %h expected %h", {out_rs1, out_rs2, out_rd}, {5'd1, 5'd2, 5'd3}); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_branch_type !== 6'b000001) begin errors++; $display("[TB] FAIL beq_branch_type: got %b expected 000001", out_branch_type); end
        checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL beq_imm: got %h expected fffffffc", out_imm); end
        checks++; if (out_instr_type !== 12'h210) begin errors++; $display("[TB] FAIL beq_type: got %h expected 210", out_instr_type); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL subbeq_drain: got %0d expected 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_lui();
        push(32'h123452B7, 32'h10C);
        checks++; if (out_instr_type !== 12'h500) begin errors++; $display("[TB] FAIL lui_type: got %h expected 500", out_instr_type); end
        checks++; if (out_imm !== 32'h12345000) begin errors++; $display("[TB] FAIL lui_imm: got %h expected 12345000", out_imm); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("[TB] FAIL lui_rd: got %0d expected 5", out_rd); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_formats();
        push(32'h00814203, 32'h110);
        push(32'h40335313, 32'h114);
        push(32'h0020A623, 32'h118);
        push(32'h00002063, 32'h11C);
        checks++; if (out_instr_type !== 12'h120) begin errors++; $display("[TB] FAIL lbu_type: got %h expected 120", out_instr_type); end
        checks++; if ({out_load_type, out_load_unsigned} !== 4'b0011) begin errors++; $display("[TB] FAIL lbu_size: got %b expected 0011", {out_load_type, out_load_unsigned}); end
        checks++; if (out_imm !== 32'd8) begin errors++; $display("[TB] FAIL lbu_imm: got %h expected 8", out_imm); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_instr_type !== 12'h182) begin errors++; $display("[TB] FAIL srai_type: got %h expected 182", out_instr_type); end
        checks++; if (out_imm !== 32'h403) begin errors++; $display("[TB] FAIL srai_imm: got %h expected 403", out_imm); end
        tick();
        checks++; if (out_instr_type !== 12'h240) begin errors++; $display("[TB] FAIL sw_type: got %h expected 240", out_instr_type); end
        checks++; if (out_load_type !== 3'b100) begin errors++; $display("[TB] FAIL sw_size: got %b expected 100", out_load_type); end
        checks++; if (out_imm !== 32'hC) begin errors++; $display("[TB] FAIL sw_imm: got %h expected c", out_imm); end
        tick();
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("[TB] FAIL badbr_illegal: got %b expected 1", out_illegal); end
        checks++; if ({out_instr_type, out_branch_type} !== 18'h0) begin errors++; $display("[TB] FAIL badbr_types: got %h expected 0", {out_instr_type, out_branch_type}); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++)
            push(32'h00000013 | ((i + 1) << 7), 32'h200 + 4 * i);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b1;
        in_line  = 32'h00000013 | (5 << 7);
        in_pc    = 32'h2F0;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_reject: got %0d expected 4", count); end
        out_ready = 1'b1;
        tick();
        checks++; if ({count, out_pc} !== {3'd3, 32'h204}) begin errors++; $display("[TB] FAIL full_pop_only: got %h expected %h", {count, out_pc}, {3'd3, 32'h204}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_back: got %b expected 1", in_ready); end
        out_ready = 1'b0;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_refill: got %0d expected 4", count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if ({count, out_pc} !== {3'd3, 32'h208}) begin errors++; $display("[TB] FAIL wrap_pop1: got %h expected %h", {count, out_pc}, {3'd3, 32'h208}); end
        in_valid = 1'b1;
        in_line  = 32'h00000013 | (6 << 7);
        in_pc    = 32'h300;
        tick();
        in_valid = 1'b0;
        checks++; if ({count, out_pc} !== {3'd3, 32'h20C}) begin errors++; $display("[TB] FAIL wrap_pushpop: got %h expected %h", {count, out_pc}, {3'd3, 32'h20C}); end
        tick();
        checks++; if ({count, out_pc, out_rd} !== {3'd2, 32'h2F0, 5'd5}) begin errors++; $display("[TB] FAIL wrap_pop2: got %h expected %h", {count, out_pc, out_rd}, {3'd2, 32'h2F0, 5'd5}); end
        tick();
        checks++; if ({count, out_pc, out_rd} !== {3'd1, 32'h300, 5'd6}) begin errors++; $display("[TB] FAIL wrap_pop3: got %h expected %h", {count, out_pc, out_rd}, {3'd1, 32'h300, 5'd6}); end
        tick();
        checks++; if ({count, out_valid} !== {3'd0, 1'b0}) begin errors++; $display("[TB] FAIL wrap_empty: got %h expected 0", {count, out_valid}); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            push(32'h00000013, 32'h400 + 4 * i);
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", count); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_line  = 32'h00000013;
        in_pc    = 32'h4F0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({count, out_valid} !== {3'd0, 1'b0}) begin errors++; $display("[TB] FAIL flush_empty: got %h expected 0", {count, out_valid}); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_dropped: got %0d expected 0", count); end
        push(32'h00000013, 32'h500);
        checks++; if ({count, out_pc} !== {3'd1, 32'h500}) begin errors++; $display("[TB] FAIL flush_resume: got %h expected %h", {count, out_pc}, {3'd1, 32'h500}); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal_x0();
        push(32'hFFFFFFFF, 32'h600);
        push(32'h00000033, 32'h604);
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("[TB] FAIL ones_illegal: got %b expected 1", out_illegal); end
        checks++; if ({out_instr_type, out_imm} !== 44'h0) begin errors++; $display("[TB] FAIL ones_type_imm: got %h expected 0", {out_instr_type, out_imm}); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL addx0_illegal: got %b expected 0", out_illegal); end
        checks++; if (out_instr_type !== 12'h201) begin errors++; $display("[TB] FAIL addx0_type: got %h expected 201", out_instr_type); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push(32'h00500093, 32'h700);
        push(32'h00500093, 32'h704);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL midreset_state: got %h expected 0", {count, out_valid, in_ready}); end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
    endtask

    // Run every scenario in order, then report the totals.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_line   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_addi();
        test_sub_beq();
        test_lui();
        test_formats();
        test_full_wrap();
        test_flush();
        test_illegal_x0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-stage decoder: decodes one RV32I instruction per cycle and buffers decoded entries in a DEPTH-entry FIFO between fetch and issue.
- The FIFO replaces the global stall with valid/ready handshakes on both sides.
- Adds LUI/AUIPC, all six branch conditions, signed and unsigned loads, SRAI/SRLI distinction, illegal-instruction detection and pipeline flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all buffered entries (branch mispredict).
- in_valid  in  1  fetch offers in_line/in_pc.
- in_ready  out  1  queue accepts this cycle.
- in_line  in  32  raw instruction.
- in_pc  in  32  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes head.
- out_instr_type  out  12  bits: 0 reg, 1 imm, 2 jal, 3 jalr, 4 branch, 5 load, 6 store, 7 sub/sra, 8 write_rd, 9 use_rs2, 10 lui, 11 auipc.
- out_branch_type  out  6  one-hot: 0 eq, 1 ne, 2 lt, 3 ge, 4 ltu, 5 geu.
- out_load_type  out  3  one-hot: 0 byte, 1 hword, 2 word (also used for store size).
- out_load_unsigned  out  1  LBU/LHU.
- out_rs1, out_rs2, out_rd  out  5 each  register tags.
- out_imm  out  32  sign-extended immediate.
- out_pc  out  32  copied from in_pc.
- out_illegal  out  1  undecodable instruction.
- count  out  CNT_W  current occupancy.

Behaviour:
- Decode is combinational on in_line. Push registers the decoded entry; it is visible on out_* the next cycle (latency 1, no same-cycle bypass).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~reset & ~flush. in_ready is 0 when full, even if a pop happens that cycle.
- out_valid = (count != 0). out_* reflect the head entry; their values are don't-care when out_valid=0.
- Simultaneous push and pop leaves count unchanged. Read and write pointers wrap modulo DEPTH.
- reset or flush, at the next edge: count=0, pointers=0, out_valid=0. A push or pop in that cycle is ignored; reset takes priority over flush. After reset: in_ready=1, count=0.
- Immediate formats:
  - I-type for imm, jalr, load.
  - S-type for store.
  - B-type for branch, bit0 = 0.
  - J-type for jal, bit0 = 0.
  - U-type {line[31:12], 12'h0} for lui/auipc.
  - All other opcodes: 0.
- Bit 7 (sub/sra) is set only when:
  - reg, funct7=0x20 and funct3 ∈ {0,5}; or
  - imm, funct3=5 and funct7=0x20.
- Bit 9 (use_rs2) = reg | branch | store.
- Bit 8 (write_rd) = ~(store | branch | illegal) & (rd != 0).
- branch_type comes from funct3 {0,1,4,5,6,7}. load_unsigned = funct3[2] for loads.
- out_illegal=1, with all of bits 0-6 and 10-11 cleared, for any of:
  - unknown opcode;
  - branch funct3 ∈ {2,3};
  - load funct3 ∈ {3,6,7};
  - store funct3 > 2;
  - jalr funct3 ≠ 0;
  - reg funct7 ∉ {0,0x20}, or funct7=0x20 with funct3 ∉ {0,5};
  - imm funct3=1 with funct7 ≠ 0;
  - imm funct3=5 with funct7 ∉ {0,0x20}.
- Illegal entries are still enqueued so the trap is raised in order.

Test Plan:
- Push 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 → next cycle out_valid=1, type bits 1 and 8 set, rd=1, imm=5, pc=0x100; count returns to 0 after the pop.
- Push 0x402081B3 (sub x3,x1,x2) then 0xFE208EE3 (beq x1,x2,-4):
  - sub → bits 0, 7, 8, 9 set.
  - beq → branch_type=6'b000001, imm=0xFFFFFFFC, write_rd=0.
- Push 0x123452B7 (lui x5,0x12345) → bit 10 set, imm=0x12345000, rd=5.
- Hold out_ready=0 and push DEPTH=4 entries → count=4, in_ready=0. A 5th offered word is not accepted. Then pop and push in the same cycle → count stays at 4 only after in_ready returns to 1 (one cycle later); FIFO order is preserved across pointer wrap.
- With 3 entries queued, assert flush together with in_valid=1 → next cycle count=0, out_valid=0; the offered word is dropped.
- Push 0xFFFFFFFF and 0x00000033 with rd=0 → first: illegal=1, write_rd=0. Second (add x0,x0,x0): illegal=0, write_rd=0. Assert reset mid-stream → count=0 on the next edge.
